// File: rtl/vector_ram_arbiter.sv
// Round-robin arbiter that funnels per-requester vector read/write beats into one vector RAM
// port and routes in-order read data back to the requester that issued each read.
module vector_ram_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int PARALLELISM     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ-1:0]                       req_write,
  input  logic [NUM_REQ*PARALLELISM*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*PARALLELISM*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic [NUM_REQ-1:0]                       resp_valid,
  output logic [PARALLELISM*DATA_WIDTH-1:0]        resp_data,
  input  logic [NUM_REQ-1:0]                       resp_ready,
  output logic                                     ram_rvalid,
  output logic                                     ram_wvalid,
  output logic [PARALLELISM*ADDR_WIDTH-1:0]        ram_addr,
  output logic [PARALLELISM*DATA_WIDTH-1:0]        ram_wdata,
  input  logic                                     ram_ready,
  input  logic                                     ram_dvalid,
  input  logic [PARALLELISM*DATA_WIDTH-1:0]        ram_data,
  output logic                                     ram_dready,
  output logic [$clog2(MAX_OUTSTANDING):0]         outstanding,
  output logic                                     err
);

  localparam int VA = PARALLELISM * ADDR_WIDTH;
  localparam int VD = PARALLELISM * DATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      fifo_mem [MAX_OUTSTANDING];
  logic [FW-1:0]      rd_idx;
  logic [FW-1:0]      wr_idx;
  logic [CW-1:0]      count;
  logic               err_q;

  logic               fifo_empty;
  logic               fifo_full;
  logic [IW-1:0]      eff_ptr;
  logic               eff_full;
  logic               eff_empty;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [IW-1:0]      grant;
  logic               accept;
  logic               push;
  logic               pop;
  logic [IW-1:0]      head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));

  // While reset is held the grant path sees a cleared pointer and an empty order FIFO.
  assign eff_ptr   = rst ? '0 : ptr;
  assign eff_full  = !rst && fifo_full;
  assign eff_empty = rst || fifo_empty;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (req_write[i] || !eff_full);
    end
  end

  // Scan from the pointer upward, wrapping, and take the first eligible requester.
  always_comb begin
    logic [IW:0] cand;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned,
    // which is what keeps synthesis from inferring a latch.
    grant_found = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, eff_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!grant_found && eligible[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant       = cand[IW-1:0];
      end
    end
  end

  assign accept = grant_found && ram_ready;
  assign push   = accept && !req_write[grant];

  always_comb begin
    ram_rvalid = 1'b0;
    ram_wvalid = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    req_ready  = '0;
    if (grant_found) begin
      ram_rvalid       = !req_write[grant];
      ram_wvalid       = req_write[grant];
      ram_addr         = req_addr[grant*VA +: VA];
      ram_wdata        = req_wdata[grant*VD +: VD];
      req_ready[grant] = ram_ready;
    end
  end

  // Read data always belongs to the oldest outstanding read, so the FIFO head owns it.
  assign head = fifo_mem[rd_idx];

  always_comb begin
    resp_valid = '0;
    ram_dready = 1'b0;
    if (!eff_empty) begin
      resp_valid[head] = ram_dvalid;
      ram_dready       = resp_ready[head];
    end
  end

  assign pop         = ram_dvalid && ram_dready;
  assign resp_data   = rst ? '0 : ram_data;
  assign outstanding = rst ? '0 : count;
  assign err         = err_q && !rst;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    if (rst) begin
      ptr    <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
      if (push) wr_idx <= wr_idx + FW'(1);
      if (pop)  rd_idx <= rd_idx + FW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      // Data with nothing outstanding is a protocol violation; the beat itself is dropped.
      if (ram_dvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  // NOTE: the order storage has no reset; entries are only read between a push and its
  // pop, and the index/count reset already makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= grant;
  end

endmodule

// File: tb/tb_vector_ram_arbiter.sv
// Randomised and directed bench for vector_ram_arbiter: a requester-level reference model
// predicts grants and read data, and a separate monitor scores the returned responses.
module tb_vector_ram_arbiter;

  localparam int N    = 2;
  localparam int P    = 4;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int MAXO = 8;
  localparam int OW   = $clog2(MAXO) + 1;

  typedef logic [P*AW-1:0] addr_vec_t;
  typedef logic [P*DW-1:0] data_vec_t;
  typedef struct {
    int        req;
    data_vec_t data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_write, req_ready, resp_valid, resp_ready;
  logic [N*P*AW-1:0] req_addr;
  logic [N*P*DW-1:0] req_wdata;
  data_vec_t         resp_data, ram_wdata, ram_data;
  addr_vec_t         ram_addr;
  logic              ram_rvalid, ram_wvalid, ram_ready, ram_dvalid, ram_dready, err;
  logic [OW-1:0]     outstanding;

  vector_ram_arbiter #(
    .NUM_REQ(N), .PARALLELISM(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .ram_rvalid(ram_rvalid), .ram_wvalid(ram_wvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ready(ram_ready),
    .ram_dvalid(ram_dvalid), .ram_data(ram_data), .ram_dready(ram_dready),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: intended memory contents, request order, pointer and error flag.
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ram_mem [int];
  int            ref_fifo [$];
  exp_t          sb_q [$];
  data_vec_t     ram_pipe [$];
  int            ref_ptr = 0;
  bit            ref_err = 0;

  bit        pend_valid [N];
  bit        pend_write [N];
  addr_vec_t pend_addr  [N];
  data_vec_t pend_wdata [N];
  int        gen_mode   [N];   // 0 manual single beat, 1 continuous reads, 2 random mix

  bit           m_accept, m_read, m_pop, m_errset, dv_hs;
  int           m_g;
  bit           ram_stall = 0;
  bit           inject_err = 0;
  logic [N-1:0] last_ready;
  logic         last_dready;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [DW-1:0] mem_init(int k);
    return DW'(32'hC0DE_0000 + k * 32'h0001_0003);
  endfunction

  function automatic data_vec_t mem_rd(bit use_ram, addr_vec_t a);
    data_vec_t r;
    for (int j = 0; j < P; j++) begin
      int k = int'(a[j*AW +: AW]);
      if (use_ram) r[j*DW +: DW] = ram_mem.exists(k) ? ram_mem[k] : mem_init(k);
      else         r[j*DW +: DW] = ref_mem.exists(k) ? ref_mem[k] : mem_init(k);
    end
    return r;
  endfunction

  task automatic drive_ports();
    for (int i = 0; i < N; i++) begin
      req_valid[i]                 = pend_valid[i];
      req_write[i]                 = pend_write[i];
      req_addr[i*P*AW +: P*AW]     = pend_addr[i];
      req_wdata[i*P*DW +: P*DW]    = pend_wdata[i];
    end
  endtask

  // Predict this cycle's grant and outputs from the arbitration rules and the model state.
  task automatic model_eval();
    int           p, g, sz;
    bit           found, full, exp_dr;
    logic [N-1:0] exp_ready;
    logic [255:0] exp_bus, act_bus;
    addr_vec_t    ga;
    data_vec_t    gd;
    sz    = ref_fifo.size();
    p     = rst ? 0 : ref_ptr;
    full  = !rst && (sz == MAXO);
    found = 0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      int i = (p + k) % N;
      if (!found && req_valid[i] && (req_write[i] || !full)) begin
        found = 1;
        g     = i;
      end
    end
    exp_ready = '0;
    if (found && ram_ready) exp_ready[g] = 1'b1;
    check("req_ready", 256'(req_ready), 256'(exp_ready));
    ga = req_addr[g*P*AW +: P*AW];
    gd = req_wdata[g*P*DW +: P*DW];
    exp_bus = found ? 256'({!req_write[g], req_write[g], ga, gd}) : '0;
    act_bus = 256'({ram_rvalid, ram_wvalid, ram_addr, ram_wdata});
    check("ram_request", act_bus, exp_bus);
    check("outstanding", 256'(outstanding), rst ? 256'(0) : 256'(sz));
    check("err", 256'(err), rst ? 256'(0) : 256'(ref_err));
    exp_dr = !rst && (sz > 0) && resp_ready[ref_fifo[0]];
    check("ram_dready", 256'(ram_dready), 256'(exp_dr));
    m_accept = found && ram_ready;
    m_g      = g;
    m_read   = m_accept && !req_write[g];
    m_pop    = !rst && ram_dvalid && exp_dr;
    m_errset = !rst && ram_dvalid && (sz == 0);
    if (m_accept && req_write[g]) begin
      for (int j = 0; j < P; j++) ref_mem[int'(ga[j*AW +: AW])] = gd[j*DW +: DW];
    end
    if (m_read && !rst) sb_q.push_back('{req: g, data: mem_rd(0, ga)});
    last_ready  = req_ready;
    last_dready = ram_dready;
  endtask

  task automatic model_commit();
    if (rst) begin
      ref_ptr = 0;
      ref_err = 0;
      ref_fifo.delete();
      sb_q.delete();
    end else begin
      if (m_accept) ref_ptr = (m_g + 1) % N;
      if (m_pop)    void'(ref_fifo.pop_front());
      if (m_read)   ref_fifo.push_back(m_g);
      if (m_errset) ref_err = 1;
    end
  endtask

  // Behavioural vector RAM: acts on whatever the DUT presents, returns reads in order.
  task automatic ram_eval();
    dv_hs = ram_dvalid && ram_dready;
    if (ram_rvalid && ram_ready) ram_pipe.push_back(mem_rd(1, ram_addr));
    if (ram_wvalid && ram_ready) begin
      for (int j = 0; j < P; j++) ram_mem[int'(ram_addr[j*AW +: AW])] = ram_wdata[j*DW +: DW];
    end
  endtask

  task automatic ram_drive();
    if (dv_hs && ram_pipe.size() > 0) void'(ram_pipe.pop_front());
    if (inject_err) begin
      ram_dvalid = 1'b1;
      ram_data   = {P{32'hDEAD_BEEF}};
    end else if (ram_pipe.size() > 0 && !ram_stall) begin
      ram_dvalid = 1'b1;
      ram_data   = ram_pipe[0];
    end else begin
      ram_dvalid = 1'b0;
      ram_data   = '0;
    end
  endtask

  task automatic new_beat(int i);
    pend_valid[i] = (gen_mode[i] == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    pend_write[i] = (gen_mode[i] == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
    for (int j = 0; j < P; j++) begin
      pend_addr[i][j*AW +: AW]  = AW'($urandom_range(0, 15));
      pend_wdata[i][j*DW +: DW] = $urandom();
    end
  endtask

  task automatic refill();
    for (int i = 0; i < N; i++) begin
      if (m_accept && m_g == i) begin
        if (gen_mode[i] == 0) pend_valid[i] = 0;
        else new_beat(i);
      end else if (!pend_valid[i] && gen_mode[i] != 0 && $urandom_range(0, 1) == 1) begin
        new_beat(i);
      end
    end
  endtask

  task automatic tick();
    drive_ports();
    @(negedge clk);
    model_eval();
    ram_eval();
    @(posedge clk);
    model_commit();
    #1;
    ram_drive();
    refill();
  endtask

  task automatic set_beat(int i, bit write, int base, logic [DW-1:0] seed);
    pend_valid[i] = 1;
    pend_write[i] = write;
    for (int j = 0; j < P; j++) begin
      pend_addr[i][j*AW +: AW]  = AW'(base + j);
      pend_wdata[i][j*DW +: DW] = seed + DW'(j);
    end
  endtask

  task automatic wait_accept(int i, string name);
    for (int c = 0; c < 50; c++) begin
      tick();
      if (m_accept && m_g == i) return;
    end
    timeout(name);
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) begin
      pend_valid[i] = 0;
      gen_mode[i]   = 0;
    end
    resp_ready = '1;
    ram_ready  = 1'b1;
    ram_stall  = 0;
    for (int c = 0; c < 200; c++) begin
      if (ref_fifo.size() == 0 && ram_pipe.size() == 0 && !ram_dvalid) return;
      tick();
    end
    timeout("drain");
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Response monitor: whenever the RAM offers data, the oldest expected read must own it.
  initial begin
    exp_t         e;
    logic [N-1:0] exp_rv;
    forever begin
      @(negedge clk);
      if (!rst && (ram_dvalid || resp_valid != '0)) begin
        exp_rv = '0;
        if (ram_dvalid && sb_q.size() > 0) exp_rv[sb_q[0].req] = 1'b1;
        check("resp_valid", 256'(resp_valid), 256'(exp_rv));
        if (ram_dvalid && sb_q.size() > 0) begin
          e = sb_q[0];
          if (resp_ready[e.req]) begin
            check("resp_data", 256'(resp_data), 256'(e.data));
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '1;
    ram_ready  = 1'b1;
    ram_dvalid = 1'b0;
    ram_data   = '0;
    for (int i = 0; i < N; i++) begin
      pend_valid[i] = 0; pend_write[i] = 0; pend_addr[i] = '0; pend_wdata[i] = '0; gen_mode[i] = 0;
    end
    tick();
    tick();
    rst = 1'b0;
    check("reset_outstanding", 256'(outstanding), 256'(0));
    check("reset_err", 256'(err), 256'(0));

    // Both requesters stream reads: grants alternate starting from requester 0.
    gen_mode[0] = 1; gen_mode[1] = 1;
    new_beat(0); new_beat(1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("alternate_grant", 256'(last_ready), (k % 2 == 0) ? 256'(2'b01) : 256'(2'b10));
    end
    drain();

    // Read from requester 0 at 0..3, then a write from requester 1, then data returns.
    ram_stall = 1;
    set_beat(0, 0, 0, 32'h0);
    wait_accept(0, "read_0_3");
    set_beat(1, 1, 0, 32'h5555_0000);
    wait_accept(1, "write_after_read");
    drain();

    // Fill all outstanding slots; a further read stalls while a write still goes through.
    ram_stall = 1;
    for (int k = 0; k < MAXO; k++) begin
      set_beat(0, 0, 4 * k, 32'h0);
      wait_accept(0, "fill_read");
    end
    check("full_outstanding", 256'(outstanding), 256'(MAXO));
    set_beat(0, 0, 40, 32'h0);
    set_beat(1, 1, 8, 32'hABCD_0000);
    tick();
    check("full_write_only", 256'(last_ready), 256'(2'b10));
    tick();
    check("full_read_held", 256'(last_ready), 256'(2'b00));
    ram_stall = 0;
    wait_accept(0, "read_after_pop");
    drain();

    // RAM back-pressure: nothing accepted and pointer frozen, then the pointer's owner wins.
    begin
      int           p0;
      logic [N-1:0] exp_g;
      set_beat(0, 0, 20, 32'h0);
      set_beat(1, 0, 24, 32'h0);
      ram_ready = 1'b0;
      p0 = ref_ptr;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("stall_no_ready", 256'(last_ready), 256'(0));
      end
      ram_ready = 1'b1;
      tick();
      exp_g = '0;
      exp_g[p0] = 1'b1;
      check("stall_grant_ptr", 256'(last_ready), 256'(exp_g));
      wait_accept(1 - p0, "stall_second");
      drain();
    end

    // Head requester refuses data: RAM data is held until it is released.
    ram_stall = 1;
    set_beat(1, 0, 12, 32'h0);
    wait_accept(1, "head_read");
    resp_ready = 2'b01;
    ram_stall  = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("head_hold_dready", 256'(last_dready), 256'(0));
      check("head_hold_outstanding", 256'(outstanding), 256'(1));
    end
    resp_ready = 2'b11;
    tick();
    check("head_release_dready", 256'(last_dready), 256'(1));
    check("head_release_pop", 256'(outstanding), 256'(0));
    drain();

    // Data with nothing outstanding sets a sticky error that only reset clears.
    inject_err = 1;
    tick();
    inject_err = 0;
    tick();
    check("err_set", 256'(err), 256'(1));
    for (int k = 0; k < 3; k++) tick();
    check("err_sticky", 256'(err), 256'(1));
    reset_pulse();
    check("err_cleared", 256'(err), 256'(0));
    check("reset_outstanding_2", 256'(outstanding), 256'(0));
    set_beat(0, 0, 28, 32'h0);
    set_beat(1, 0, 32, 32'h0);
    tick();
    check("reset_ptr_zero", 256'(last_ready), 256'(2'b01));
    drain();

    // Reset with reads in flight: their late data is unowned and flags an error.
    ram_stall = 1;
    set_beat(0, 0, 44, 32'h0);
    wait_accept(0, "inflight_read_a");
    set_beat(0, 0, 48, 32'h0);
    wait_accept(0, "inflight_read_b");
    reset_pulse();
    ram_stall = 0;
    tick();
    tick();
    check("stale_data_err", 256'(err), 256'(1));
    ram_pipe.delete();
    tick();
    reset_pulse();
    drain();

    // Random traffic with random back-pressure on every side.
    gen_mode[0] = 2; gen_mode[1] = 2;
    for (int c = 0; c < 1500; c++) begin
      resp_ready = N'($urandom_range(0, (1 << N) - 1));
      ram_ready  = ($urandom_range(0, 4) != 0);
      ram_stall  = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();
    check("scoreboard_empty", 256'(sb_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_ram_arbiter.md
VECTOR_RAM_ARBITER -- requirements
Module: vector_ram_arbiter

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- NUM_REQ, 2, number of requesters.
- PARALLELISM, 4, elements per vector beat.
- DATA_WIDTH, 32, element width.
- ADDR_WIDTH, 16, element address width.
- MAX_OUTSTANDING, 8, read beats in flight; power of 2.
REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, NUM_REQ, per-requester beat valid.
- req_write, in, NUM_REQ, 1 = write beat, 0 = read beat.
- req_addr, in, NUM_REQ*PARALLELISM*ADDR_WIDTH, per-requester element addresses.
- req_wdata, in, NUM_REQ*PARALLELISM*DATA_WIDTH, per-requester write data.
- req_ready, out, NUM_REQ, beat accepted this cycle.
- resp_valid, out, NUM_REQ, read data valid to the requester.
- resp_data, out, PARALLELISM*DATA_WIDTH, read data, shared by all requesters.
- resp_ready, in, NUM_REQ, requester accepts read data.
- ram_rvalid, out, 1, read beat to the vector RAM.
- ram_wvalid, out, 1, write beat to the vector RAM.
- ram_addr, out, PARALLELISM*ADDR_WIDTH, granted addresses.
- ram_wdata, out, PARALLELISM*DATA_WIDTH, granted write data.
- ram_ready, in, 1, vector RAM accepts a beat.
- ram_dvalid, in, 1, vector RAM read data valid.
- ram_data, in, PARALLELISM*DATA_WIDTH, vector RAM read data.
- ram_dready, out, 1, arbiter accepts RAM read data.
- outstanding, out, clog2(MAX_OUTSTANDING)+1, read beats in flight.
- err, out, 1, sticky protocol error.

Function
REQ-003 Eligibility: requester i is eligible when req_valid[i]=1, and for reads also when outstanding < MAX_OUTSTANDING.
REQ-004 Grant: a round-robin pointer ptr selects the first eligible requester at or after ptr, wrapping modulo NUM_REQ; grant is combinational, zero cycles latency.
REQ-005 Output drive: ram_rvalid/ram_wvalid reflect the granted beat type; ram_addr and ram_wdata are muxed from the granted requester; all four are 0 when there is no grant.
REQ-006 Accept: req_ready[g]=1 only for the granted g and only when ram_ready=1; all other req_ready bits are 0.
REQ-007 Pointer update: on accept, ptr <= (g+1) mod NUM_REQ on the next edge; otherwise ptr holds.
REQ-008 Read order FIFO: an accepted read pushes g into the order FIFO (depth MAX_OUTSTANDING); an accepted write pushes nothing.
REQ-009 Response routing: resp_data = ram_data; resp_valid[h] = ram_dvalid, where h is the FIFO head; all other resp_valid bits are 0; ram_dready = resp_ready[h].
REQ-010 Pop: the FIFO pops when ram_dvalid && ram_dready.
REQ-011 Outstanding counter: outstanding = FIFO occupancy; +1 on push, -1 on pop, unchanged on simultaneous push and pop.
REQ-012 Full FIFO: when full, reads are ineligible and writes still arbitrate; a pop and a push in the same cycle when full is legal only if the push was eligible at the start of that cycle.
REQ-013 Empty FIFO: when empty, ram_dready=0 and all resp_valid=0; ram_dvalid=1 while empty sets err=1, and the beat is ignored.
REQ-014 err stays 1 until reset.
REQ-015 Request stability: requester inputs are not registered; a requester holds valid, addr and data until its req_ready is 1.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL set ptr=0, empty the FIFO, and set outstanding=0 and err=0.
REQ-017 During reset, all outputs SHALL be 0 except the combinational grant path, which behaves per REQ-004..006 with ptr=0 and an empty FIFO.
REQ-018 Reset asserted mid-operation SHALL discard in-flight read routing; RAM data arriving after reset SHALL set err per REQ-013.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Both requesters read continuously, ram_ready=1 -> grants alternate 0,1,0,1; ptr toggles each cycle.
- Req0 reads addresses 0..3, then req1 writes; RAM returns data D -> resp_valid[0]=1 with resp_data=D; req1 receives no response.
- Issue 8 reads with no data returned (MAX_OUTSTANDING=8) -> outstanding=8; a 9th read is held at req_ready=0; a write in the same cycle is accepted.
- ram_ready=0 for 3 cycles with req_valid=2'b11 -> req_ready=0 and ptr unchanged; ram_ready=1 -> the requester at ptr is granted.
- Head requester holds resp_ready=0 -> ram_dready=0 and data held; on release, pop happens and outstanding decrements by 1.
- ram_dvalid=1 with an empty FIFO -> err=1 and stays 1; rst=1 for one cycle -> err=0, outstanding=0, ptr=0.
